// File: rtl/slurm32_icache_if.sv
// rtl/slurm32_icache_if.sv - fetch-port and memory-read bundle of the SLURM32 instruction cache
interface slurm32_icache_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int BITS         = 32
);
    logic                    instruction_request;
    logic [ADDRESS_BITS-1:0] instruction_address;
    logic                    instruction_valid;
    logic [BITS-1:0]         instruction_in;
    logic                    cache_flush;
    logic                    mem_rd_req;
    logic [ADDRESS_BITS-1:0] mem_rd_addr;
    logic                    mem_rd_valid;
    logic [BITS-1:0]         mem_rd_data;

    modport slave (
        input  instruction_request, instruction_address, cache_flush, mem_rd_valid, mem_rd_data,
        output instruction_valid, instruction_in, mem_rd_req, mem_rd_addr
    );

    modport master (
        output instruction_request, instruction_address, cache_flush, mem_rd_valid, mem_rd_data,
        input  instruction_valid, instruction_in, mem_rd_req, mem_rd_addr
    );
endinterface

// File: rtl/slurm32_icache.sv
// rtl/slurm32_icache.sv - direct-mapped read-only instruction cache with whole-line fill
module slurm32_icache #(
    parameter int ADDRESS_BITS = 32,
    parameter int BITS         = 32,
    parameter int LINE_BITS    = 6,
    parameter int WORD_BITS    = 2
) (
    input logic             CLK,
    input logic             RST,
    slurm32_icache_if.slave bus
);
    localparam int TAG_BITS = ADDRESS_BITS - LINE_BITS - WORD_BITS - 2;
    localparam int LINES    = 1 << LINE_BITS;
    localparam int WORDS    = 1 << (LINE_BITS + WORD_BITS);

    typedef enum logic [1:0] {LOOKUP, FILL, COMMIT} state_t;

    state_t state, next_state;

    logic [TAG_BITS-1:0]  tag_ram [LINES];
    logic [BITS-1:0]      data_ram [WORDS];
    logic [LINES-1:0]     valid_bits;

    logic [TAG_BITS-1:0]  req_tag;
    logic [LINE_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [BITS-1:0]      rd_data;
    logic                 lookup_pending;
    logic                 flush_pending;
    logic [WORD_BITS-1:0] word;

    logic [WORD_BITS-1:0] addr_offset;
    logic [LINE_BITS-1:0] addr_index;
    logic [TAG_BITS-1:0]  addr_tag;
    logic                 unused_addr_bits;

    logic hit, miss, sample, fill_accept, last_word;

    assign addr_offset      = bus.instruction_address[WORD_BITS+1:2];
    assign addr_index       = bus.instruction_address[LINE_BITS+WORD_BITS+1:WORD_BITS+2];
    assign addr_tag         = bus.instruction_address[ADDRESS_BITS-1:LINE_BITS+WORD_BITS+2];
    assign unused_addr_bits = ^bus.instruction_address[1:0];

    // The miss-detect cycle refuses new addresses; the pipeline re-presents after the stall.
    assign hit         = lookup_pending && valid_bits[req_index] && (rd_tag == req_tag);
    assign miss        = (state == LOOKUP) && lookup_pending && !hit;
    assign sample      = (state == LOOKUP) && bus.instruction_request && !miss;
    assign fill_accept = (state == FILL) && bus.mem_rd_valid;
    assign last_word   = &word;

    always_comb begin
        next_state      = state;
        bus.mem_rd_req  = 1'b0;
        bus.mem_rd_addr = '0;
        unique case (state)
            LOOKUP: begin
                if (miss) next_state = FILL;
            end
            FILL: begin
                bus.mem_rd_req  = 1'b1;
                bus.mem_rd_addr = {req_tag, req_index, word, 2'b00};
                if (fill_accept && last_word) next_state = COMMIT;
            end
            COMMIT: begin
                next_state = LOOKUP;
            end
            default: begin
                next_state = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                 <= LOOKUP;
            valid_bits            <= '0;
            flush_pending         <= 1'b0;
            word                  <= '0;
            lookup_pending        <= 1'b0;
            req_tag               <= '0;
            req_index             <= '0;
            bus.instruction_valid <= 1'b0;
            bus.instruction_in    <= '0;
        end else begin
            state                 <= next_state;
            lookup_pending        <= sample;
            bus.instruction_valid <= (state == LOOKUP) && hit;
            if (sample) begin
                req_tag   <= addr_tag;
                req_index <= addr_index;
            end
            if ((state == LOOKUP) && hit) bus.instruction_in <= rd_data;
            if (fill_accept) word <= word + 1'b1;
            // A flush seen during a fill must still win over the line being committed.
            unique case (state)
                LOOKUP: begin
                    if (bus.cache_flush) valid_bits <= '0;
                end
                FILL: begin
                    if (bus.cache_flush) flush_pending <= 1'b1;
                end
                COMMIT: begin
                    flush_pending <= 1'b0;
                    if (flush_pending || bus.cache_flush) valid_bits <= '0;
                    else valid_bits[req_index] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (sample) begin
            rd_tag  <= tag_ram[addr_index];
            rd_data <= data_ram[{addr_index, addr_offset}];
        end
        if (fill_accept) data_ram[{req_index, word}] <= bus.mem_rd_data;
        if (state == COMMIT) tag_ram[req_index] <= req_tag;
    end
endmodule
